// File: rtl/controller_hub_pkg.sv
// Shared types, constants and sizing helpers for the controller hub and its
// per-player channel logic.
package controller_hub_pkg;

  // Which players are allowed to request a game start with their C button.
  typedef enum logic {
    START_P0  = 1'b0,
    START_ANY = 1'b1
  } start_mode_e;

  // Stick rest position for the default 8-bit axis width.
  localparam logic [7:0] STICK_NEUTRAL = 8'h80;

  // Stick rest position for an arbitrary axis width: only the MSB set.
  function automatic logic [31:0] stick_neutral(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Width of a per-button debounce counter (counts up to frames-1).
  function automatic int unsigned debounce_cnt_w(input int unsigned frames);
    return cnt_width(frames);
  endfunction

  // Width of a per-channel missed-frame counter (saturates at frames).
  function automatic int unsigned timeout_cnt_w(input int unsigned frames);
    return cnt_width(frames);
  endfunction

endpackage

// File: rtl/controller_channel.sv
// One player channel: captures driver samples into a shadow, publishes them
// once per frame tick, debounces Z/C in frame units and tracks whether the
// driver is still delivering samples.
module controller_channel
  import controller_hub_pkg::*;
#(
  parameter int STICK_W         = 8,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int TIMEOUT_FRAMES  = 30
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic               tick,
  input  logic               in_valid,
  input  logic [STICK_W-1:0] in_stick_x,
  input  logic [STICK_W-1:0] in_stick_y,
  input  logic               in_z,
  input  logic               in_c,
  output logic [STICK_W-1:0] out_stick_x,
  output logic [STICK_W-1:0] out_stick_y,
  output logic               out_z,
  output logic               out_c,
  output logic               connected,
  output logic               c_rise
);

  localparam int DW = debounce_cnt_w(DEBOUNCE_FRAMES);
  localparam int TW = timeout_cnt_w(TIMEOUT_FRAMES);
  localparam logic [DW-1:0]      DEB_LAST = DW'(DEBOUNCE_FRAMES - 1);
  localparam logic [TW-1:0]      MISS_MAX = TW'(TIMEOUT_FRAMES);
  localparam logic [STICK_W-1:0] NEUTRAL  = STICK_W'(stick_neutral(STICK_W));
  localparam int BTN_Z = 0;
  localparam int BTN_C = 1;

  logic [STICK_W-1:0]     sh_x_q, sh_x_d;
  logic [STICK_W-1:0]     sh_y_q, sh_y_d;
  logic [1:0]             sh_btn_q, sh_btn_d;
  logic                   seen_q, seen_d;
  logic [TW-1:0]          miss_q, miss_d;
  logic                   conn_q, conn_d;
  logic [STICK_W-1:0]     pub_x_q, pub_x_d;
  logic [STICK_W-1:0]     pub_y_q, pub_y_d;
  logic [1:0]             deb_q, deb_d;
  logic [1:0][DW-1:0]     dcnt_q, dcnt_d;

  // Next-state: tick-time publish/debounce/timeout, then sample capture.
  // Capture is applied last so a sample arriving with the tick lands in the
  // shadow for the following frame while the tick publishes the old shadow.
  always_comb begin
    sh_x_d   = sh_x_q;
    sh_y_d   = sh_y_q;
    sh_btn_d = sh_btn_q;
    seen_d   = seen_q;
    miss_d   = miss_q;
    conn_d   = conn_q;
    pub_x_d  = pub_x_q;
    pub_y_d  = pub_y_q;
    deb_d    = deb_q;
    dcnt_d   = dcnt_q;

    if (tick) begin
      seen_d = 1'b0;
      if (seen_q) begin
        miss_d  = '0;
        conn_d  = 1'b1;
        pub_x_d = sh_x_q;
        pub_y_d = sh_y_q;
      end else begin
        if (miss_q != MISS_MAX) begin
          miss_d = miss_q + 1'b1;
        end
        if (miss_d == MISS_MAX) begin
          conn_d = 1'b0;
        end
      end

      // A button flips only after DEBOUNCE_FRAMES consecutive differing frames.
      for (int b = 0; b < 2; b++) begin
        if (sh_btn_q[b] == deb_q[b]) begin
          dcnt_d[b] = '0;
        end else if (dcnt_q[b] == DEB_LAST) begin
          deb_d[b]  = ~deb_q[b];
          dcnt_d[b] = '0;
        end else begin
          dcnt_d[b] = dcnt_q[b] + 1'b1;
        end
      end

      // A silent controller must look idle to the game.
      if (!conn_d) begin
        pub_x_d = NEUTRAL;
        pub_y_d = NEUTRAL;
        deb_d   = '0;
        dcnt_d  = '0;
      end
    end

    if (in_valid) begin
      sh_x_d   = in_stick_x;
      sh_y_d   = in_stick_y;
      sh_btn_d = {in_c, in_z};
      seen_d   = 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      sh_x_q   <= NEUTRAL;
      sh_y_q   <= NEUTRAL;
      sh_btn_q <= '0;
      seen_q   <= 1'b0;
      miss_q   <= '0;
      conn_q   <= 1'b0;
      pub_x_q  <= NEUTRAL;
      pub_y_q  <= NEUTRAL;
      deb_q    <= '0;
      dcnt_q   <= '0;
    end else begin
      sh_x_q   <= sh_x_d;
      sh_y_q   <= sh_y_d;
      sh_btn_q <= sh_btn_d;
      seen_q   <= seen_d;
      miss_q   <= miss_d;
      conn_q   <= conn_d;
      pub_x_q  <= pub_x_d;
      pub_y_q  <= pub_y_d;
      deb_q    <= deb_d;
      dcnt_q   <= dcnt_d;
    end
  end

  assign out_stick_x = pub_x_q;
  assign out_stick_y = pub_y_q;
  assign out_z       = deb_q[BTN_Z];
  assign out_c       = deb_q[BTN_C];
  assign connected   = conn_q;
  // Debounced C about to go 0->1 on this tick (only meaningful when tick=1).
  assign c_rise      = tick & deb_d[BTN_C] & ~deb_q[BTN_C] & conn_d;

endmodule

// File: rtl/controller_hub.sv
// N-player input front end: synchronises vsync into a frame tick, fans the
// tick out to one controller_channel per player, generates the game start
// request and holds the game in reset for a fixed time after power-up.
module controller_hub
  import controller_hub_pkg::*;
#(
  parameter int          NUM_PLAYERS     = 2,
  parameter int          STICK_W         = 8,
  parameter int          RST_HOLD        = 2500000,
  parameter int          DEBOUNCE_FRAMES = 3,
  parameter int          TIMEOUT_FRAMES  = 30,
  parameter start_mode_e START_MODE      = START_P0
) (
  input  logic                           clkin,
  input  logic                           rst,
  input  logic                           frame_sync,
  input  logic [NUM_PLAYERS-1:0]         in_valid,
  input  logic [NUM_PLAYERS*STICK_W-1:0] in_stick_x,
  input  logic [NUM_PLAYERS*STICK_W-1:0] in_stick_y,
  input  logic [NUM_PLAYERS-1:0]         in_z,
  input  logic [NUM_PLAYERS-1:0]         in_c,
  output logic [NUM_PLAYERS*STICK_W-1:0] out_stick_x,
  output logic [NUM_PLAYERS*STICK_W-1:0] out_stick_y,
  output logic [NUM_PLAYERS-1:0]         out_z,
  output logic [NUM_PLAYERS-1:0]         out_c,
  output logic [NUM_PLAYERS-1:0]         connected,
  output logic                           frame_tick,
  output logic                           start_pulse,
  output logic                           game_rst
);

  localparam int RW = cnt_width(RST_HOLD);
  localparam logic [RW-1:0] HOLD_VAL = RW'(RST_HOLD);
  localparam logic [NUM_PLAYERS-1:0] START_SEL =
    (START_MODE == START_ANY) ? {NUM_PLAYERS{1'b1}} : NUM_PLAYERS'(1);

  // vsync idles high, so the whole pipeline resets high to avoid a false tick.
  logic fs_meta_q, fs_sync_q, fs_cur_q, fs_prev_q;
  logic tick;

  logic [RW-1:0] hold_cnt_q, hold_cnt_d;
  logic          game_rst_q, game_rst_d;
  logic          frame_tick_q;
  logic          start_q, start_d;

  logic [NUM_PLAYERS-1:0] c_rise;

  // Two-flop synchroniser followed by the current/previous edge register.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      fs_meta_q <= 1'b1;
      fs_sync_q <= 1'b1;
      fs_cur_q  <= 1'b1;
      fs_prev_q <= 1'b1;
    end else begin
      fs_meta_q <= frame_sync;
      fs_sync_q <= fs_meta_q;
      fs_cur_q  <= fs_sync_q;
      fs_prev_q <= fs_cur_q;
    end
  end

  // Internal tick: synchronised vsync seen falling.
  assign tick = fs_prev_q & ~fs_cur_q;

  // Power-up hold counter and start request qualification.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (hold_cnt_q < HOLD_VAL) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
    game_rst_d = (hold_cnt_d < HOLD_VAL);
    // A rise seen while the game is held in reset is dropped, not deferred.
    start_d = tick & ~game_rst_q & (|(c_rise & START_SEL));
  end

  // Reset-hold, frame tick and start pulse registers.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      hold_cnt_q   <= '0;
      game_rst_q   <= 1'b1;
      frame_tick_q <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      game_rst_q   <= game_rst_d;
      frame_tick_q <= tick;
      start_q      <= start_d;
    end
  end

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_chan
    controller_channel #(
      .STICK_W         (STICK_W),
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
      .TIMEOUT_FRAMES  (TIMEOUT_FRAMES)
    ) u_chan (
      .clkin       (clkin),
      .rst         (rst),
      .tick        (tick),
      .in_valid    (in_valid[gi]),
      .in_stick_x  (in_stick_x[gi*STICK_W +: STICK_W]),
      .in_stick_y  (in_stick_y[gi*STICK_W +: STICK_W]),
      .in_z        (in_z[gi]),
      .in_c        (in_c[gi]),
      .out_stick_x (out_stick_x[gi*STICK_W +: STICK_W]),
      .out_stick_y (out_stick_y[gi*STICK_W +: STICK_W]),
      .out_z       (out_z[gi]),
      .out_c       (out_c[gi]),
      .connected   (connected[gi]),
      .c_rise      (c_rise[gi])
    );
  end

  assign frame_tick  = frame_tick_q;
  assign start_pulse = start_q;
  assign game_rst    = game_rst_q;

endmodule

// File: tb/tb_controller_hub.sv
// Randomised scoreboard bench for controller_hub: the stimulus thread drives
// samples and vsync and pushes the expected per-frame outputs; a monitor pops
// them whenever frame_tick is seen and checks outputs hold between frames.
module tb_controller_hub;
  import controller_hub_pkg::*;

  localparam int NP = 2;
  localparam int SW = 8;
  localparam int RH = 16;
  localparam int DB = 3;
  localparam int TO = 4;
  localparam start_mode_e SM = START_ANY;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_sync = 1'b1;
  logic [NP-1:0]    in_valid = '0;
  logic [NP*SW-1:0] in_x = '0;
  logic [NP*SW-1:0] in_y = '0;
  logic [NP-1:0]    in_z = '0;
  logic [NP-1:0]    in_c = '0;
  logic [NP*SW-1:0] out_x, out_y;
  logic [NP-1:0]    out_z, out_c, connected;
  logic             frame_tick, start_pulse, game_rst;

  controller_hub #(
    .NUM_PLAYERS(NP), .STICK_W(SW), .RST_HOLD(RH),
    .DEBOUNCE_FRAMES(DB), .TIMEOUT_FRAMES(TO), .START_MODE(SM)
  ) dut (
    .clkin(clk), .rst(rst_n), .frame_sync(frame_sync),
    .in_valid(in_valid), .in_stick_x(in_x), .in_stick_y(in_y),
    .in_z(in_z), .in_c(in_c),
    .out_stick_x(out_x), .out_stick_y(out_y), .out_z(out_z), .out_c(out_c),
    .connected(connected), .frame_tick(frame_tick),
    .start_pulse(start_pulse), .game_rst(game_rst)
  );

  always #5 clk = ~clk;

  // Clock edges since rst was released: after edge n this reads n.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic [NP*SW-1:0] x;
    logic [NP*SW-1:0] y;
    logic [NP-1:0]    z;
    logic [NP-1:0]    c;
    logic [NP-1:0]    conn;
    logic             start;
    int               tick_edge;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.x = {NP{STICK_NEUTRAL}};
    e.y = {NP{STICK_NEUTRAL}};
    e.z = '0;
    e.c = '0;
    e.conn = '0;
    e.start = 1'b0;
    e.tick_edge = 0;
    return e;
  endfunction

  // ---------------- reference model (frame-level view of the spec) --------
  int m_seen [NP];
  int m_sx   [NP];
  int m_sy   [NP];
  int m_raw  [NP][2];   // latest captured raw buttons: [0]=Z, [1]=C
  int m_miss [NP];
  int m_conn [NP];
  int m_px   [NP];
  int m_py   [NP];
  int m_deb  [NP][2];
  int m_cnt  [NP][2];

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_seen[i] = 0; m_sx[i] = 128; m_sy[i] = 128; m_miss[i] = 0;
      m_conn[i] = 0; m_px[i] = 128; m_py[i] = 128;
      for (int b = 0; b < 2; b++) begin
        m_raw[i][b] = 0; m_deb[i][b] = 0; m_cnt[i][b] = 0;
      end
    end
  endtask

  // One frame boundary. fall_cyc is the edge count when vsync went low, so
  // the fall is sampled at edge fall_cyc+1 and the tick shows at fall_cyc+4.
  task automatic model_tick(input int fall_cyc);
    exp_t e;
    bit   rise;
    int   old_c;
    rise = 0;
    for (int i = 0; i < NP; i++) begin
      if (m_seen[i] != 0) begin
        m_miss[i] = 0; m_conn[i] = 1; m_px[i] = m_sx[i]; m_py[i] = m_sy[i];
      end else begin
        if (m_miss[i] < TO) m_miss[i]++;
        if (m_miss[i] == TO) m_conn[i] = 0;
      end
      m_seen[i] = 0;
      old_c = m_deb[i][1];
      for (int b = 0; b < 2; b++) begin
        if (m_raw[i][b] == m_deb[i][b]) m_cnt[i][b] = 0;
        else begin
          m_cnt[i][b]++;
          if (m_cnt[i][b] == DB) begin
            m_deb[i][b] = 1 - m_deb[i][b];
            m_cnt[i][b] = 0;
          end
        end
      end
      if (m_conn[i] == 0) begin
        m_px[i] = 128; m_py[i] = 128;
        m_deb[i][0] = 0; m_deb[i][1] = 0; m_cnt[i][0] = 0; m_cnt[i][1] = 0;
      end
      if ((SM == START_ANY || i == 0) && old_c == 0 && m_deb[i][1] == 1) rise = 1;
      e.x[i*SW +: SW] = SW'(m_px[i]);
      e.y[i*SW +: SW] = SW'(m_py[i]);
      e.z[i] = (m_deb[i][0] != 0);
      e.c[i] = (m_deb[i][1] != 0);
      e.conn[i] = (m_conn[i] != 0);
    end
    // game_rst is low after edge n once n >= RH; the tick edge is fall_cyc+4.
    e.start = rise && ((fall_cyc + 3) >= RH);
    e.tick_edge = fall_cyc + 4;
    exp_q.push_back(e);
  endtask

  // ---------------- stimulus policy ----------------
  int pr [NP];   // % chance of a sample in ordinary cycles
  int cpr[NP];   // % chance of a sample in the cycle that coincides with the tick
  int fx [NP];
  int fy [NP];
  int cy [NP];   // stick_y used in the coincident cycle (-1 = as fy)
  int fz [NP];
  int fc [NP];

  task automatic policy_default();
    for (int i = 0; i < NP; i++) begin
      pr[i] = 60; cpr[i] = 30; fx[i] = -1; fy[i] = -1; cy[i] = -1; fz[i] = -1; fc[i] = -1;
    end
  endtask

  task automatic drive(input bit coll);
    int p, xs, ys, zs, cs;
    for (int i = 0; i < NP; i++) begin
      p  = coll ? cpr[i] : pr[i];
      xs = (fx[i] >= 0) ? fx[i] : int'($urandom_range(0, 255));
      ys = (fy[i] >= 0) ? fy[i] : int'($urandom_range(0, 255));
      if (coll && cy[i] >= 0) ys = cy[i];
      zs = (fz[i] >= 0) ? fz[i] : int'($urandom_range(0, 1));
      cs = (fc[i] >= 0) ? fc[i] : int'($urandom_range(0, 1));
      in_x[i*SW +: SW] = SW'(xs);
      in_y[i*SW +: SW] = SW'(ys);
      in_z[i] = zs[0];
      in_c[i] = cs[0];
      if (int'($urandom_range(0, 99)) < p) begin
        in_valid[i] = 1'b1;
        m_seen[i] = 1; m_sx[i] = xs; m_sy[i] = ys; m_raw[i][0] = zs; m_raw[i][1] = cs;
      end else begin
        in_valid[i] = 1'b0;
      end
    end
  endtask

  // One video frame: body cycles of samples, then vsync low for two cycles.
  // The model tick is taken after the last cycle that precedes the tick edge;
  // the following drive lands exactly on the tick edge.
  task automatic frame(input int body);
    int fall_cyc;
    for (int i = 0; i < body; i++) begin
      @(negedge clk); drive(1'b0);
    end
    @(negedge clk); frame_sync = 1'b0; fall_cyc = cyc; drive(1'b0);
    @(negedge clk); drive(1'b0);
    @(negedge clk); frame_sync = 1'b1; drive(1'b0);
    @(negedge clk); model_tick(fall_cyc); drive(1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t last, e;
    last = reset_exp();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = reset_exp();
        chk("rst_frame_tick", frame_tick, 1'b0);
        chk("rst_start", start_pulse, 1'b0);
        chk("rst_stick_x", out_x, last.x);
        chk("rst_stick_y", out_y, last.y);
        chk("rst_buttons", {out_z, out_c}, {last.z, last.c});
        chk("rst_connected", connected, last.conn);
      end else if (frame_tick) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tick_unexpected: got frame_tick=1 expected 0 (no frame pending) at t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("tick_edge", 64'(cyc), 64'(e.tick_edge));
          chk("stick_x", out_x, e.x);
          chk("stick_y", out_y, e.y);
          chk("out_z", out_z, e.z);
          chk("out_c", out_c, e.c);
          chk("connected", connected, e.conn);
          chk("start_pulse", start_pulse, e.start);
          last = e;
        end
      end else begin
        chk("hold_stick_x", out_x, last.x);
        chk("hold_stick_y", out_y, last.y);
        chk("hold_buttons", {out_z, out_c, connected}, {last.z, last.c, last.conn});
        chk("hold_start", start_pulse, 1'b0);
      end
      chk("game_rst", game_rst, (!rst_n || cyc < RH));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached limit without finishing", $time);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int zseq[10];
    int cseq[7];
    model_reset();
    policy_default();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;

    // C held by player 1 straight out of reset: rises while game_rst=1.
    pr[1] = 100; cpr[1] = 100; fc[1] = 1; fc[0] = 0;
    repeat (4) frame(0);
    policy_default();
    repeat (3) frame(1);

    // Asynchronous reset in the middle of a frame with samples pending.
    @(negedge clk); drive(1'b0);
    @(negedge clk); drive(1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_game_rst", game_rst, 1'b1);
    chk("async_frame_tick", frame_tick, 1'b0);
    chk("async_start", start_pulse, 1'b0);
    chk("async_connected", connected, '0);
    chk("async_stick_x", out_x, {NP{STICK_NEUTRAL}});
    chk("async_stick_y", out_y, {NP{STICK_NEUTRAL}});
    chk("async_buttons", {out_z, out_c}, '0);
    in_valid = '0;
    model_reset();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Latency: channel 0 stick_x 0xC8 published with connected on the tick.
    pr[0] = 100; cpr[0] = 0; fx[0] = 8'hC8;
    frame(1);
    policy_default();
    repeat (4) frame(int'($urandom_range(0, 3)));

    // Debounce of Z on channel 0: 2 frames (no flip), 3 frames on, 3 off.
    zseq = '{1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
    pr[0] = 100; cpr[0] = 100; fc[0] = 0;
    foreach (zseq[k]) begin
      fz[0] = zseq[k];
      frame(1);
    end

    // Start request from player 1 with game_rst low.
    cseq = '{0, 0, 0, 1, 1, 1, 1};
    pr[1] = 100; cpr[1] = 100;
    foreach (cseq[k]) begin
      fc[1] = cseq[k];
      frame(0);
    end
    policy_default();

    // Timeout on channel 0, then recovery.
    pr[0] = 0; cpr[0] = 0;
    repeat (5) frame(1);
    pr[0] = 100; cpr[0] = 100;
    repeat (2) frame(1);

    // Sample on channel 1 coinciding with the tick goes to the next frame.
    pr[1] = 100; cpr[1] = 0; fy[1] = 8'h33;
    frame(1);
    cpr[1] = 100; cy[1] = 8'h10;
    frame(1);
    pr[1] = 0; cpr[1] = 0;
    frame(1);
    policy_default();

    // Randomised frames.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < NP; i++) begin
        pr[i]  = int'($urandom_range(0, 100));
        cpr[i] = int'($urandom_range(0, 100));
      end
      frame(int'($urandom_range(0, 3)));
    end

    repeat (6) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_hub.md
# controller_hub

Parametrised N-player input front end between the per-player nunchuck drivers and the game state updater. Captures each driver's samples, publishes them once per video frame aligned to vsync, debounces buttons in frame units, detects silent/disconnected controllers, generates the start pulse, and holds the game in reset after power-up. It replaces the fixed two-player wiring and the ad-hoc reset-delay counter at top level.

## Interface
- NUM_PLAYERS, 2: controller channels (1..8)
- STICK_W, 8: stick axis width
- RST_HOLD, 2500000: clkin cycles game_rst is held after rst release
- DEBOUNCE_FRAMES, 3: consecutive differing frames before a debounced button flips (>=1)
- TIMEOUT_FRAMES, 30: frames without a sample before a channel is disconnected (>=1)
- START_MODE, START_P0: START_P0 = only player 0 C starts; START_ANY = any player's C starts
- clkin  in  1  system clock; all logic in this domain
- rst  in  1  asynchronous, active-low reset
- frame_sync  in  1  VGA vsync (active low, vga_clk domain), synchronised internally
- in_valid  in  NUM_PLAYERS  one-cycle strobe per channel: new sample present
- in_stick_x, in_stick_y  in  NUM_PLAYERS*STICK_W  raw stick, channel i at [i*STICK_W +: STICK_W]
- in_z, in_c  in  NUM_PLAYERS  raw buttons, active high
- out_stick_x, out_stick_y  out  NUM_PLAYERS*STICK_W  per-frame published stick
- out_z, out_c  out  NUM_PLAYERS  debounced buttons
- connected  out  NUM_PLAYERS  channel alive
- frame_tick  out  1  one-cycle pulse per frame
- start_pulse  out  1  one-cycle game start request
- game_rst  out  1  active-high game reset

## Operation
- Reset (rst low, asynchronous): game_rst=1, reset counter=0, frame_tick=0, start_pulse=0, connected=0, out sticks=STICK_NEUTRAL, out buttons=0, shadows/debounce/miss counters cleared. Applies mid-operation with no exceptions.
- Reset hold: after rst rises, counter ($clog2(RST_HOLD+1) bits) increments each cycle; game_rst=1 while counter<RST_HOLD, then 0 and counter saturates.
- Frame tick: frame_sync through 2 flops, then edge register; internal tick t=previous high & current low.
- Capture: in_valid[i] loads channel i shadow (sticks, z, c) and sets seen[i]. Latest sample before a tick wins.
- On t, per channel:
  - seen=1: miss counter cleared, connected=1, shadow sticks published.
  - seen=0: miss counter increments (saturating at TIMEOUT_FRAMES); on reaching TIMEOUT_FRAMES, connected=0.
  - seen cleared.
  - Debounce per button: raw==debounced clears its counter; otherwise counter increments, and when it reaches DEBOUNCE_FRAMES the debounced value flips and counter clears.
  - Disconnected channel: sticks forced STICK_NEUTRAL, debounced buttons and counters forced 0.
- Simultaneous in_valid and t: tick publishes the prior shadow and clears seen; the new sample loads the shadow and sets seen (counts toward next frame).
- Start: at t, start_pulse=1 if a selected channel's debounced C goes 0->1 on this tick, channel connected, and game_rst=0. Suppressed entirely while game_rst=1 (no queued pulse).

## Timing
- frame_sync falling edge first sampled at clkin edge k -> frame_tick high for cycle k+3; out sticks, out buttons, connected, start_pulse update on that same edge.
- Outputs stable between frame_ticks; all registered, no input-to-output combinational path.
- Minimum frame_sync low/high: 2 clkin cycles each.
- game_rst falls exactly RST_HOLD cycles after the first clkin edge with rst high.

## Structure
- controller_hub_pkg: STICK_NEUTRAL (1<<(STICK_W-1), 0x80 at 8 bits), start_mode_e {START_P0, START_ANY}, debounce/timeout counter width functions.
- Sub-module controller_channel: one channel's shadow, seen flag, miss counter, two debouncers, publish regs; instantiated NUM_PLAYERS times via generate. Top holds synchroniser, reset hold, start logic.

## Test plan
- Reset hold (RST_HOLD=16): release rst -> game_rst=1 for 16 cycles then 0; sticks 0x80, buttons 0, connected=0; assert rst mid-frame -> all outputs back to reset values immediately.
- Latency: ch0 in_valid with stick_x=0xC8, frame_sync falls first sampled at edge k -> frame_tick at k+3, out_stick_x[7:0]=0xC8, connected[0]=1 same cycle.
- Debounce (DEBOUNCE_FRAMES=3): raw z=1 for 2 frames then 0 -> out_z stays 0; z=1 for 3 frames -> out_z rises on 3rd tick; release likewise needs 3 frames.
- Start (START_ANY): player 1 debounced C rises with game_rst=0 -> start_pulse exactly 1 cycle on that tick; same during game_rst=1 -> no pulse ever.
- Timeout (TIMEOUT_FRAMES=4): stop ch0 valids -> connected[0]=0 on 4th tick, stick 0x80, out_c=0; resume valid -> connected[0]=1 next tick.
- Collision: ch1 in_valid with stick_y=0x10 in same cycle as internal tick -> not published this tick; published 0x10 at the following tick.
